bit_pack_4to16_seq: RTL and testbench
=====================================

BIT_PACK_4TO16_SEQ -- requirements
Module: bit_pack_4to16_seq

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 4, width of one selected chunk received from the upstream 8x4 bit-selection stage.
REQ-002 SHALL have parameter PACK_FACTOR, default 4, number of chunks per output word.
REQ-003 SHALL have parameter OUT_DATA_WIDTH, default IN_DATA_WIDTH*PACK_FACTOR (16), output word width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, number of completed words buffered.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_en, input, 1 bit: block enable; when low, no chunk is accepted.
REQ-008 SHALL have port i_valid, input, 1 bit: i_data_bus holds a valid chunk.
REQ-009 SHALL have port i_data_bus, input, IN_DATA_WIDTH: chunk to pack.
REQ-010 SHALL have port i_flush, input, 1 bit: emit the partial word zero-padded.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts the output word.
REQ-012 SHALL have port o_valid, output, 1 bit: o_data_bus holds a valid word.
REQ-013 SHALL have port o_data_bus, output, OUT_DATA_WIDTH: packed word.
REQ-014 SHALL have port o_lane_cnt, output, $clog2(PACK_FACTOR): chunks held in the partial word.
REQ-015 SHALL have port o_overflow, output, 1 bit: sticky word-drop flag.

Function
REQ-016 SHALL accept a chunk on each edge where i_en & i_valid is high; there is no input backpressure.
REQ-017 SHALL place accepted chunk k of a word at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH], lane 0 first (LSB-first).
REQ-018 SHALL implement the lane counter as states LANE0..LANE(PACK_FACTOR-1): advance on accept; wrap LANE3->LANE0 on accept while completing the word.
REQ-019 SHALL push the completed word into the FIFO on the same edge its last chunk is accepted, so o_valid rises one cycle after the 4th chunk's accepting edge.
REQ-020 SHALL drive o_valid = FIFO non-empty and o_data_bus = FIFO head, or all-zero when empty.
REQ-021 SHALL pop the head on each edge where o_valid & i_ready is high.
REQ-022 SHALL allow a simultaneous push and pop when full, with occupancy unchanged and no drop.
REQ-023 SHALL drop the pushed word when the FIFO is full and no pop occurs that edge, and set o_overflow.
REQ-024 SHALL keep o_overflow set until reset.
REQ-025 SHALL reset the partial-word register to zero after every push so that unused lanes read zero.

Reset
REQ-026 SHALL, while rst is high, asynchronously force o_valid=0, o_data_bus=0, o_lane_cnt=0, o_overflow=0, the FIFO empty and the partial word zero.
REQ-027 SHALL discard a partial word in progress when rst is asserted mid-word; the first chunk after release goes to lane 0.

Configuration
REQ-028 SHALL, with BIT_PACK_FLUSH_EN defined, push the partial word (zero-padded) on i_flush when o_lane_cnt>0 or a chunk is accepted that edge, and return the counter to LANE0.
REQ-029 SHALL, with BIT_PACK_FLUSH_EN defined, include a chunk accepted on the flush edge in the flushed word.
REQ-030 SHALL, with BIT_PACK_FLUSH_EN defined, treat a flush coinciding with the 4th chunk as one normal full-word push.
REQ-031 SHALL, with BIT_PACK_FLUSH_EN defined, treat i_flush with an empty partial word and no accept as a no-op.
REQ-032 SHALL, with BIT_PACK_FLUSH_EN undefined, keep the i_flush port but ignore it and add no flush logic.

Structure
REQ-033 SHALL place the default widths, PACK_FACTOR, FIFO_DEPTH and the lane-state encoding in shared package bit_pack_pkg.
REQ-034 SHALL implement the word buffer as sub-module pack_word_fifo (sync FIFO, async reset, full/empty, simultaneous push/pop).

Verification
REQ-035 SHALL cover: chunks 0x1,0x2,0x3,0x4 on consecutive cycles with i_ready=1 -> o_valid for exactly one cycle, one cycle after 4th accept, o_data_bus=0x4321.
REQ-036 SHALL cover: i_ready=0, 12 chunks 0x1..0xC -> words 0x4321 and 0x8765 held, third word dropped, o_overflow=1; then i_ready=1 -> two words out, o_overflow stays 1.
REQ-037 SHALL cover: FIFO full and 4th chunk accepted on the same edge as a pop -> no drop, occupancy stays 2, o_overflow=0.
REQ-038 SHALL cover (BIT_PACK_FLUSH_EN): chunks 0xA,0xB, then 0xC with i_flush -> o_data_bus=0x0CBA and o_lane_cnt=0; without the macro -> no output and o_lane_cnt=3.
REQ-039 SHALL cover: rst pulsed after 2 chunks, then 0x5,0x6,0x7,0x8 -> o_data_bus=0x8765 and no residue of the earlier chunks.
REQ-040 SHALL cover: i_en=0 with i_valid=1 for 8 cycles -> o_lane_cnt stays 0 and o_valid stays 0.

Source files
------------

// File: rtl/bit_pack_pkg.sv
// Shared defaults and lane-state encoding for the 4-bit to 16-bit chunk packer.
package bit_pack_pkg;

    localparam int unsigned DEF_IN_DATA_WIDTH = 4;
    localparam int unsigned DEF_PACK_FACTOR   = 4;
    localparam int unsigned DEF_FIFO_DEPTH    = 2;

    // Lane states are a binary count from LANE0 up to lane_last(PACK_FACTOR).
    localparam int unsigned LANE0 = 0;

    function automatic int unsigned lane_last(input int unsigned pack_factor);
        return pack_factor - 1;
    endfunction

endpackage

// File: rtl/pack_word_fifo.sv
// Synchronous word FIFO with async reset; a push while full is accepted only
// if a pop happens on the same edge. head reads zero when empty.
module pack_word_fifo
    import bit_pack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_IN_DATA_WIDTH * DEF_PACK_FACTOR,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(rd_ptr + 1'b1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bit_pack_4to16_seq.sv
// Packs IN_DATA_WIDTH chunks LSB-first into OUT_DATA_WIDTH words and buffers them.
// Optional zero-padded partial-word flush is enabled by defining BIT_PACK_FLUSH_EN.
module bit_pack_4to16_seq
    import bit_pack_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
    parameter int unsigned PACK_FACTOR    = DEF_PACK_FACTOR,
    parameter int unsigned OUT_DATA_WIDTH = IN_DATA_WIDTH * PACK_FACTOR,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    input  logic [IN_DATA_WIDTH-1:0]       i_data_bus,
    input  logic                           i_flush,
    input  logic                           i_ready,
    output logic                           o_valid,
    output logic [OUT_DATA_WIDTH-1:0]      o_data_bus,
    output logic [$clog2(PACK_FACTOR)-1:0] o_lane_cnt,
    output logic                           o_overflow
);

    localparam int unsigned LANE_W = $clog2(PACK_FACTOR);
    localparam logic [LANE_W-1:0] LANE_FIRST = LANE_W'(LANE0);
    localparam logic [LANE_W-1:0] LANE_END   = LANE_W'(lane_last(PACK_FACTOR));

    logic [LANE_W-1:0]         lane;
    logic [LANE_W-1:0]         lane_nxt;
    logic [OUT_DATA_WIDTH-1:0] word;
    logic [OUT_DATA_WIDTH-1:0] word_nxt;
    logic [OUT_DATA_WIDTH-1:0] merged;
    logic [IN_DATA_WIDTH-1:0]  chunk;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic                      overflow;

    assign accept     = i_en & i_valid;
    assign chunk      = accept ? i_data_bus : '0;
    assign merged     = word | (OUT_DATA_WIDTH'(chunk) << (32'(lane) * IN_DATA_WIDTH));
    assign o_valid    = ~empty;
    assign pop        = o_valid & i_ready;
    assign o_lane_cnt = lane;
    assign o_overflow = overflow;

`ifndef BIT_PACK_FLUSH_EN
    logic unused_flush;
    assign unused_flush = i_flush;
`endif

    // Lane state and partial-word next-state; the word register clears on every push.
    always_comb begin
        lane_nxt = lane;
        word_nxt = word;
        push     = 1'b0;
        if (accept) begin
            if (lane == LANE_END) begin
                push     = 1'b1;
                lane_nxt = LANE_FIRST;
                word_nxt = '0;
            end else begin
                lane_nxt = LANE_W'(lane + 1'b1);
                word_nxt = merged;
            end
        end
`ifdef BIT_PACK_FLUSH_EN
        if (i_flush && !push && (accept || (lane != LANE_FIRST))) begin
            push     = 1'b1;
            lane_nxt = LANE_FIRST;
            word_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= LANE_FIRST;
            word     <= '0;
            overflow <= 1'b0;
        end else begin
            lane <= lane_nxt;
            word <= word_nxt;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    pack_word_fifo #(
        .WIDTH (OUT_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (merged),
        .pop       (pop),
        .head      (o_data_bus),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_bit_pack_4to16_seq.sv
// Self-checking bench for bit_pack_4to16_seq: directed scenarios plus random
// traffic compared against a queue-based word/chunk model.
module tb_bit_pack_4to16_seq;

    localparam int unsigned DEPTH = 2;
`ifdef BIT_PACK_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_valid;
    logic [3:0]  i_data_bus;
    logic        i_flush;
    logic        i_ready;
    logic        o_valid;
    logic [15:0] o_data_bus;
    logic [1:0]  o_lane_cnt;
    logic        o_overflow;

    int total  = 0;
    int passed = 0;

    logic [15:0] mq[$];
    logic [3:0]  part[$];
    bit          m_ovf;

    bit_pack_4to16_seq dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_flush    (i_flush),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_lane_cnt (o_lane_cnt),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'(mq.size() != 0));
        check({tag, "_data"}, 32'(o_data_bus), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check({tag, "_lane"}, 32'(o_lane_cnt), 32'(part.size()));
        check({tag, "_ovf"}, 32'(o_overflow), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input bit en, input bit valid, input logic [3:0] d,
                        input bit fl, input bit rdy, input string tag);
        bit          pop_now;
        bit          have_push;
        logic [15:0] w;
        i_en = en; i_valid = valid; i_data_bus = d; i_flush = fl; i_ready = rdy;
        pop_now   = rdy && (mq.size() != 0);
        have_push = 1'b0;
        w         = '0;
        if (en && valid) part.push_back(d);
        if (part.size() == 4 || (FLUSH_EN && fl && part.size() > 0)) begin
            foreach (part[k]) w = w | (16'(part[k]) << (4 * k));
            part.delete();
            have_push = 1'b1;
        end
        if (pop_now) void'(mq.pop_front());
        if (have_push) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_en = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_flush = 1'b0; i_ready = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data_bus), 32'd0);
        check("rst_lane", 32'(o_lane_cnt), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        mq.delete();
        part.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_en = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_flush = 1'b0; i_ready = 1'b0;
        #2;
        do_reset();

        // Four chunks with downstream ready: one word, valid for one cycle.
        for (int i = 1; i <= 4; i++) step(1, 1, 4'(i), 0, 1, "t035");
        check("t035_word_valid", 32'(o_valid), 32'd1);
        check("t035_word_data", 32'(o_data_bus), 32'h4321);
        step(0, 0, 4'h0, 0, 1, "t035_idle");
        check("t035_one_cycle", 32'(o_valid), 32'd0);

        // Twelve chunks with no ready: third word dropped, sticky overflow.
        do_reset();
        for (int i = 1; i <= 12; i++) step(1, 1, 4'(i), 0, 0, "t036_fill");
        check("t036_head", 32'(o_data_bus), 32'h4321);
        check("t036_ovf", 32'(o_overflow), 32'd1);
        step(0, 0, 4'h0, 0, 1, "t036_drain");
        check("t036_second", 32'(o_data_bus), 32'h8765);
        check("t036_ovf_sticky", 32'(o_overflow), 32'd1);
        step(0, 0, 4'h0, 0, 1, "t036_drain");
        check("t036_empty", 32'(o_valid), 32'd0);
        check("t036_ovf_end", 32'(o_overflow), 32'd1);

        // Full FIFO, completing chunk on the same edge as a pop: no drop.
        do_reset();
        for (int i = 1; i <= 11; i++) step(1, 1, 4'(i), 0, 0, "t037_fill");
        step(1, 1, 4'hC, 0, 1, "t037_pushpop");
        check("t037_head", 32'(o_data_bus), 32'h8765);
        check("t037_ovf", 32'(o_overflow), 32'd0);
        step(0, 0, 4'h0, 0, 1, "t037_drain");
        check("t037_second", 32'(o_data_bus), 32'hCBA9);
        step(0, 0, 4'h0, 0, 1, "t037_drain");
        check("t037_empty", 32'(o_valid), 32'd0);

        // Flush with a chunk on the flush edge.
        do_reset();
        step(1, 1, 4'hA, 0, 0, "t038");
        step(1, 1, 4'hB, 0, 0, "t038");
        step(1, 1, 4'hC, 1, 0, "t038_flush");
`ifdef BIT_PACK_FLUSH_EN
        check("t038_data", 32'(o_data_bus), 32'h0CBA);
        check("t038_lane", 32'(o_lane_cnt), 32'd0);
`else
        check("t038_novalid", 32'(o_valid), 32'd0);
        check("t038_lane", 32'(o_lane_cnt), 32'd3);
`endif

        // Reset mid-word discards the partial word.
        do_reset();
        step(1, 1, 4'h1, 0, 0, "t039_pre");
        step(1, 1, 4'h2, 0, 0, "t039_pre");
        do_reset();
        for (int i = 5; i <= 8; i++) step(1, 1, 4'(i), 0, 0, "t039");
        check("t039_data", 32'(o_data_bus), 32'h8765);

        // Valid without enable accepts nothing.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 4'($urandom), 0, 1, "t040");
        check("t040_lane", 32'(o_lane_cnt), 32'd0);
        check("t040_valid", 32'(o_valid), 32'd0);

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
